// File: rtl/clct_group_busy_timer.sv
// clct_group_busy_timer
//   Per-key-group dead-time timers that produce the busy flags for the
//   best-1-of-7 pattern selector. Each accepted CLCT reloads the timer of
//   its key group. That group's bsy flag then stays high for cfg_dead
//   clocks, which blocks new patterns there until the drift window closes.
//
// Optional feature macro: CLCT_BUSY_NEIGHBOR_EN
//   When it is defined, an event within EDGE half-strips of a group boundary
//   also reloads the adjacent group's timer.
//
// Ports
//   clock     in   main 40 MHz clock
//   reset_n   in   asynchronous active-low reset
//   evt_vld   in   registered sorter result valid strobe
//   evt_key   in   {group, half-strip key} of the best candidate
//   evt_bsy   in   sorter found every candidate busy (no CLCT carried)
//   cfg_en    in   timers enabled; 0 clears every timer
//   cfg_dead  in   dead-time, in clocks, loaded on each accepted event
//   cnt_clr   in   synchronous clear of evt_cnt
//   bsy       out  per-group busy flags
//   bsy_any   out  OR of bsy
//   evt_err   out  registered pulse for an event with an out-of-range group
//   evt_cnt   out  saturating count of accepted events
`timescale 1ns/1ps
module clct_group_busy_timer #(
  parameter int unsigned MXGRP   = 7,
  parameter int unsigned MXKEYB  = 5,
  parameter int unsigned MXKEYBX = 8,
  parameter int unsigned MXDTB   = 4,
  parameter int unsigned MXCNTB  = 16,
  parameter int unsigned EDGE    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               evt_vld,
  input  logic [MXKEYBX-1:0] evt_key,
  input  logic               evt_bsy,
  input  logic               cfg_en,
  input  logic [MXDTB-1:0]   cfg_dead,
  input  logic               cnt_clr,
  output logic [MXGRP-1:0]   bsy,
  output logic               bsy_any,
  output logic               evt_err,
  output logic [MXCNTB-1:0]  evt_cnt
);

  localparam int unsigned GRPB  = MXKEYBX - MXKEYB;
  localparam int unsigned HSMAX = (1 << MXKEYB) - 1;

`ifdef CLCT_BUSY_NEIGHBOR_EN
  localparam bit NBR_EN = 1'b1;
`else
  localparam bit NBR_EN = 1'b0;
`endif

  logic [GRPB-1:0]   grp;
  logic [MXKEYB-1:0] hs;
  logic              grp_ok;
  logic              accept;
  logic              near_lo;
  logic              near_hi;
  logic [MXGRP-1:0]  load;

  logic [MXDTB-1:0]  tmr_q [MXGRP];
  logic [MXDTB-1:0]  tmr_d [MXGRP];
  logic              err_q, err_d;
  logic [MXCNTB-1:0] cnt_q, cnt_d;

  assign grp     = evt_key[MXKEYBX-1:MXKEYB];
  assign hs      = evt_key[MXKEYB-1:0];
  assign grp_ok  = 32'(grp) < MXGRP;
  assign accept  = evt_vld & ~evt_bsy & cfg_en & grp_ok;
  // The edge flags are always computed. NBR_EN is a constant, so the
  // neighbour terms disappear when the feature is not built in.
  assign near_lo = NBR_EN && (32'(hs) < EDGE);
  assign near_hi = NBR_EN && (32'(hs) > HSMAX - EDGE);

  // One-hot load decode. The neighbour terms select g = grp-1 or g = grp+1.
  // The loop bounds keep them inside 0..MXGRP-1.
  always_comb begin
    load = '0;
    for (int unsigned g = 0; g < MXGRP; g++) begin
      if (accept && 32'(grp) == g)               load[g] = 1'b1;
      if (accept && near_lo && 32'(grp) == g + 1) load[g] = 1'b1;
      if (accept && near_hi && 32'(grp) + 1 == g) load[g] = 1'b1;
    end
  end

  // A load wins over the decrement, so a re-trigger restarts the full window.
  always_comb begin
    for (int unsigned g = 0; g < MXGRP; g++) begin
      tmr_d[g] = tmr_q[g];
      if (!cfg_en)                tmr_d[g] = '0;
      else if (load[g])           tmr_d[g] = cfg_dead;
      else if (tmr_q[g] != '0)    tmr_d[g] = tmr_q[g] - 1'b1;
    end
  end

  always_comb begin
    err_d = evt_vld & ~grp_ok;
    cnt_d = cnt_q;
    if (cnt_clr)                     cnt_d = '0;
    else if (accept && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned g = 0; g < MXGRP; g++) tmr_q[g] <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int unsigned g = 0; g < MXGRP; g++) tmr_q[g] <= tmr_d[g];
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Busy is decoded straight from the timer registers. Because of this, an
  // asynchronous reset drops it at once.
  always_comb begin
    bsy = '0;
    for (int unsigned g = 0; g < MXGRP; g++) bsy[g] = (tmr_q[g] != '0);
  end

  assign bsy_any = |bsy;
  assign evt_err = err_q;
  assign evt_cnt = cnt_q;

endmodule

// File: tb/tb_clct_group_busy_timer.sv
`timescale 1ns/1ps
module tb_clct_group_busy_timer;

`ifdef CLCT_BUSY_NEIGHBOR_EN
  localparam bit NBR = 1'b1;
`else
  localparam bit NBR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        evt_vld;
  logic [7:0]  evt_key;
  logic        evt_bsy;
  logic        cfg_en;
  logic [3:0]  cfg_dead;
  logic        cnt_clr;
  logic [6:0]  bsy;
  logic        bsy_any;
  logic        evt_err;
  logic [15:0] evt_cnt;

  always #5 clock = ~clock;

  clct_group_busy_timer #(
    .MXGRP   (7),
    .MXKEYB  (5),
    .MXKEYBX (8),
    .MXDTB   (4),
    .MXCNTB  (16),
    .EDGE    (2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .evt_vld  (evt_vld),
    .evt_key  (evt_key),
    .evt_bsy  (evt_bsy),
    .cfg_en   (cfg_en),
    .cfg_dead (cfg_dead),
    .cnt_clr  (cnt_clr),
    .bsy      (bsy),
    .bsy_any  (bsy_any),
    .evt_err  (evt_err),
    .evt_cnt  (evt_cnt)
  );

  typedef struct {
    logic        en;
    logic [3:0]  dead;
    logic        vld;
    logic [7:0]  key;
    logic        ebsy;
    logic        clr;
    logic [6:0]  x_bsy;
    logic        x_err;
    logic [15:0] x_cnt;
  } vec_t;

  typedef struct {
    logic [6:0]  bsy;
    logic        err;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [3:0] dead, input logic vld,
                     input logic [7:0] key, input logic ebsy, input logic clr,
                     input logic [6:0] xb, input logic xe, input logic [15:0] xc);
    vec_t v;
    v.en = en; v.dead = dead; v.vld = vld; v.key = key; v.ebsy = ebsy; v.clr = clr;
    v.x_bsy = xb; v.x_err = xe; v.x_cnt = xc;
    vt.push_back(v);
  endtask

  task automatic idle(input logic [3:0] dead, input logic [6:0] xb, input logic [15:0] xc);
    add(1'b1, dead, 1'b0, 8'h00, 1'b0, 1'b0, xb, 1'b0, xc);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Each vector's expectation goes into the scoreboard when the vector is
  // driven. It is popped and compared once the edge has produced the output.
  task automatic run_vectors;
    vec_t v;
    exp_t e;
    while (vt.size() > 0) begin
      v = vt.pop_front();
      cfg_en = v.en; cfg_dead = v.dead; evt_vld = v.vld; evt_key = v.key;
      evt_bsy = v.ebsy; cnt_clr = v.clr;
      e.bsy = v.x_bsy; e.err = v.x_err; e.cnt = v.x_cnt; e.idx = vec_idx;
      sbq.push_back(e);
      vec_idx++;
      tick();
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
        e = sbq.pop_front();
        check($sformatf("vec%0d.bsy", e.idx), 32'(bsy), 32'(e.bsy));
        check($sformatf("vec%0d.bsy_any", e.idx), 32'(bsy_any), 32'(|e.bsy));
        check($sformatf("vec%0d.evt_err", e.idx), 32'(evt_err), 32'(e.err));
        check($sformatf("vec%0d.evt_cnt", e.idx), 32'(evt_cnt), 32'(e.cnt));
      end
    end
    evt_vld = 1'b0; cnt_clr = 1'b0; evt_bsy = 1'b0;
  endtask

  logic [6:0] nb_hi;
  logic [6:0] nb_lo;

  initial begin
    reset_n = 1'b0; evt_vld = 1'b0; evt_key = '0; evt_bsy = 1'b0;
    cfg_en = 1'b0; cfg_dead = '0; cnt_clr = 1'b0;
    nb_hi = NBR ? 7'b0000110 : 7'b0000010;  // key 3F: group 1, hs 31
    nb_lo = NBR ? 7'b0000110 : 7'b0000100;  // key 41: group 2, hs 1

    tick(); tick();
    check("reset.bsy", 32'(bsy), 32'd0);
    check("reset.bsy_any", 32'(bsy_any), 32'd0);
    check("reset.evt_err", 32'(evt_err), 32'd0);
    check("reset.evt_cnt", 32'(evt_cnt), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic window, five clocks long
    add(1, 5, 1, 8'h45, 0, 0, 7'b0000100, 0, 1);
    for (int i = 0; i < 4; i++) idle(5, 7'b0000100, 1);
    idle(5, 7'b0000000, 1);
    // Re-trigger restarts the window
    add(1, 4, 1, 8'h60, 0, 0, 7'b0001000, 0, 2);
    idle(4, 7'b0001000, 2);
    add(1, 4, 1, 8'h60, 0, 0, 7'b0001000, 0, 3);
    for (int i = 0; i < 3; i++) idle(4, 7'b0001000, 3);
    idle(4, 7'b0000000, 3);
    // evt_bsy ignored; dead=0 counts but never asserts busy; group 7 is an error
    add(1, 5, 1, 8'h20, 1, 0, 7'b0000000, 0, 3);
    add(1, 0, 1, 8'h40, 0, 0, 7'b0000000, 0, 4);
    add(1, 5, 1, 8'hE0, 0, 0, 7'b0000000, 1, 4);
    idle(5, 7'b0000000, 4);
    // cfg_en low clears timers, blocks events, but still flags errors
    add(1, 5, 1, 8'h80, 0, 0, 7'b0010000, 0, 5);
    add(0, 5, 1, 8'hE0, 0, 0, 7'b0000000, 1, 5);
    add(0, 5, 1, 8'h20, 0, 0, 7'b0000000, 0, 5);
    idle(5, 7'b0000000, 5);
    // A cfg_dead change does not disturb a running timer
    add(1, 3, 1, 8'hA0, 0, 0, 7'b0100000, 0, 6);
    idle(15, 7'b0100000, 6);
    idle(15, 7'b0100000, 6);
    idle(15, 7'b0000000, 6);
    // Group boundary keys
    add(1, 3, 1, 8'h3F, 0, 0, nb_hi, 0, 7);
    idle(3, nb_hi, 7); idle(3, nb_hi, 7); idle(3, 7'b0000000, 7);
    add(1, 3, 1, 8'hDF, 0, 0, 7'b1000000, 0, 8);
    idle(3, 7'b1000000, 8); idle(3, 7'b1000000, 8); idle(3, 7'b0000000, 8);
    add(1, 1, 1, 8'h41, 0, 0, nb_lo, 0, 9);
    idle(1, 7'b0000000, 9);
    add(1, 1, 1, 8'h00, 0, 0, 7'b0000001, 0, 10);
    idle(1, 7'b0000000, 10);
    // cnt_clr, alone and together with an event
    add(1, 1, 0, 8'h00, 0, 1, 7'b0000000, 0, 0);
    add(1, 2, 1, 8'h80, 0, 1, 7'b0010000, 0, 0);
    idle(2, 7'b0010000, 0);
    idle(2, 7'b0000000, 0);
    run_vectors();

    // Reset in the middle of a window
    cfg_dead = 4'd15; evt_vld = 1'b1; evt_key = 8'h00;
    tick();
    evt_vld = 1'b0;
    tick(); tick(); tick();
    check("midwin.bsy", 32'(bsy), 32'h01);
    check("midwin.evt_cnt", 32'(evt_cnt), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst.bsy", 32'(bsy), 32'd0);
    check("async_rst.bsy_any", 32'(bsy_any), 32'd0);
    check("async_rst.evt_cnt", 32'(evt_cnt), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("post_rst.bsy", 32'(bsy), 32'd0);
    check("post_rst.evt_cnt", 32'(evt_cnt), 32'd0);
    check("post_rst.evt_err", 32'(evt_err), 32'd0);

    // Counter saturation
    cfg_en = 1'b1; cfg_dead = 4'd1; evt_vld = 1'b1; evt_key = 8'h00;
    for (int i = 0; i < 65534; i++) tick();
    check("sat.pre", 32'(evt_cnt), 32'hFFFE);
    add(1, 1, 1, 8'h00, 0, 0, 7'b0000001, 0, 16'hFFFF);
    add(1, 1, 1, 8'h00, 0, 0, 7'b0000001, 0, 16'hFFFF);
    add(1, 1, 1, 8'h00, 0, 0, 7'b0000001, 0, 16'hFFFF);
    add(1, 1, 1, 8'h00, 0, 1, 7'b0000001, 0, 16'h0000);
    idle(1, 7'b0000000, 0);
    run_vectors();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
